sr_flipflop_bank: RTL and testbench
===================================

Name: sr_flipflop_bank

Overview:
- Clocked, parametrised bank of N independent SR storage channels; successor to the single unclocked SR gate.
- Each channel has optional input synchronisers and a runtime-selectable resolution for S=R=1: hold, set-dominant, reset-dominant, or JK toggle.
- Replaces the undefined S=R=1 condition with defined behaviour, a per-channel illegal-event pulse and a saturating illegal-event counter.
- Used wherever sticky flags, debounced latches or status bits fed from asynchronous sources are needed.

Parameters:
- CHANNELS, 4, number of independent SR channels (1..32).
- SYNC_STAGES, 2, synchroniser flops on S and R per channel (0 = no synchroniser, otherwise 2..3).
- CNT_W, 8, width of the shared saturating illegal-event counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- N_RESET  in  1  asynchronous, active-low reset.
- S  in  CHANNELS  per-channel set request, level-sensitive.
- R  in  CHANNELS  per-channel reset request, level-sensitive.
- MODE  in  2  S=R=1 resolution: 00 hold, 01 set-dominant, 10 reset-dominant, 11 toggle (JK).
- CNT_CLR  in  1  synchronous clear of ILLEGAL_CNT.
- Q  out  CHANNELS  stored state.
- NOT_Q  out  CHANNELS  always the bitwise complement of Q, including during reset.
- ILLEGAL  out  CHANNELS  one-cycle pulse per channel when synchronised S=R=1 in modes 00/01/10.
- ILLEGAL_CNT  out  CNT_W  saturating count of cycles in which any ILLEGAL bit is set.

Behaviour:
- Reset (N_RESET=0, asynchronous): Q=0, NOT_Q=all 1, ILLEGAL=0, ILLEGAL_CNT=0, synchroniser flops=0. Never X or Z.
- Reset release: first update on the next rising CLK edge.
- Reset mid-operation: all state is discarded immediately; no partial updates.
- Synchroniser: Ss/Rs are S/R delayed by SYNC_STAGES edges. With SYNC_STAGES=0, Ss=S and Rs=R.
- Latency: an input change is reflected on Q after SYNC_STAGES+1 rising edges.
- Per-channel next state from (Ss,Rs), decided each edge:
  - 00: hold.
  - 10: Q<=1.
  - 01: Q<=0.
  - 11: MODE 00 hold; 01 Q<=1; 10 Q<=0; 11 Q<=~Q (toggles every cycle while held).
- ILLEGAL[i] is registered: it is set on the edge where Ss[i]&Rs[i]=1 and MODE!=11, and cleared otherwise. It stays high for consecutive cycles if S=R=1 persists. It is never asserted in MODE 11.
- ILLEGAL_CNT: increments by 1 on each edge where the next ILLEGAL is non-zero (one count per cycle, regardless of how many channels are illegal).
  - Saturates at 2^CNT_W-1; no wrap.
  - CNT_CLR has priority over increment: counter becomes 0 that edge.
- MODE changes take effect on the next edge. MODE itself is not synchronised; the system keeps it quasi-static.
- Channels are fully independent; simultaneous events on different channels are all processed in the same cycle.

Decomposition:
- Package sr_bank_pkg:
  - typedef enum logic [1:0] sr_mode_t {SR_HOLD, SR_SET_DOM, SR_RST_DOM, SR_TOGGLE}.
  - Function sr_next(q, s, r, mode) returning the next state.
- Sub-module sr_sync (parameter STAGES, per-bit synchroniser chain with async active-low reset), instantiated per channel for S and R via generate.
- Top level holds the Q register vector, ILLEGAL register and counter.

Test Plan (CHANNELS=4, SYNC_STAGES=2, CNT_W=4 unless stated):
1. Assert N_RESET=0 mid-run with Q=4'b1010 -> Q=0000 and NOT_Q=1111 immediately, before the next CLK edge, and ILLEGAL_CNT=0.
2. S=4'b0001 for one cycle, then 0 -> Q[0]=1 exactly 3 edges after S rises and stays latched. Then R=4'b0001 -> Q[0]=0 3 edges later; NOT_Q tracks the complement throughout.
3. MODE=01, S=R=4'b0010 held 3 cycles -> Q[1]=1, ILLEGAL[1] high 3 consecutive cycles, ILLEGAL_CNT=3. Repeat with MODE=10 -> Q[1]=0; MODE=00 -> Q[1] holds its prior value.
4. MODE=11, S=R=4'b0100 held 4 cycles from Q[2]=0 -> Q[2] sequence 1,0,1,0; ILLEGAL stays 0; ILLEGAL_CNT unchanged.
5. MODE=01, S=R=4'b1111 held 20 cycles -> ILLEGAL=1111 each cycle, ILLEGAL_CNT saturates at 15. Assert CNT_CLR together with an illegal cycle -> counter reads 0 next cycle.
6. SYNC_STAGES=0 build: S=4'b1000 -> Q[3]=1 after 1 edge; mixed S=0001, R=0010 in the same cycle -> Q=...01 with both channels updated in that edge.

Source files
------------

// File: rtl/sr_flipflop_bank_pkg.sv
// Shared types and per-channel next-state rules for the clocked SR storage bank.
// S=R=1 no longer means "undefined": it is resolved by a runtime-selected mode.
package sr_bank_pkg;

  typedef enum logic [1:0] {
    SR_HOLD    = 2'b00,
    SR_SET_DOM = 2'b01,
    SR_RST_DOM = 2'b10,
    SR_TOGGLE  = 2'b11
  } sr_mode_t;

  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input sr_mode_t mode);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      2'b11: begin
        case (mode)
          SR_SET_DOM: nxt = 1'b1;
          SR_RST_DOM: nxt = 1'b0;
          SR_TOGGLE:  nxt = ~q;
          default:    nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

  // Toggle mode gives S=R=1 a legitimate meaning, so it is never flagged there.
  function automatic logic sr_is_illegal(input logic s, input logic r, input sr_mode_t mode);
    return s & r & (mode != SR_TOGGLE);
  endfunction

endpackage

// File: rtl/sr_flipflop_bank_sync.sv
// Single-bit synchroniser chain: output is the input delayed by STAGES rising edges.
// Only instantiated when STAGES >= 1; the bypass case is handled by the caller.
module sr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d    = chain_q;
    chain_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

  if (STAGES < 1) begin : g_bad_stages
    $error("sr_sync: STAGES must be at least 1");
  end

endmodule

// File: rtl/sr_flipflop_bank.sv
// Bank of independent clocked SR channels with optional input synchronisers,
// selectable S=R=1 resolution, per-channel illegal pulses and a shared saturating counter.
module sr_flipflop_bank
  import sr_bank_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                CLK,
  input  logic                N_RESET,
  input  logic [CHANNELS-1:0] S,
  input  logic [CHANNELS-1:0] R,
  input  logic [1:0]          MODE,
  input  logic                CNT_CLR,
  output logic [CHANNELS-1:0] Q,
  output logic [CHANNELS-1:0] NOT_Q,
  output logic [CHANNELS-1:0] ILLEGAL,
  output logic [CNT_W-1:0]    ILLEGAL_CNT
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] ss;
  logic [CHANNELS-1:0] rs;

  logic [CHANNELS-1:0] q_q;
  logic [CHANNELS-1:0] q_d;
  logic [CHANNELS-1:0] illegal_q;
  logic [CHANNELS-1:0] illegal_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  sr_mode_t            mode;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    if (SYNC_STAGES == 0) begin : g_direct
      assign ss[i] = S[i];
      assign rs[i] = R[i];
    end else begin : g_sync
      sr_sync #(.STAGES(SYNC_STAGES)) u_sync_s (
        .clk   (CLK),
        .rst_n (N_RESET),
        .d     (S[i]),
        .q     (ss[i])
      );
      sr_sync #(.STAGES(SYNC_STAGES)) u_sync_r (
        .clk   (CLK),
        .rst_n (N_RESET),
        .d     (R[i]),
        .q     (rs[i])
      );
    end
  end

  // MODE is treated as quasi-static and sampled directly, without synchronisation.
  assign mode = sr_mode_t'(MODE);

  always_comb begin
    q_d       = q_q;
    illegal_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      q_d[i]       = sr_next(q_q[i], ss[i], rs[i], mode);
      illegal_d[i] = sr_is_illegal(ss[i], rs[i], mode);
    end
  end

  // One count per cycle with any illegal channel; clear beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR) begin
      cnt_d = '0;
    end else if ((|illegal_d) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      q_q       <= '0;
      illegal_q <= '0;
      cnt_q     <= '0;
    end else begin
      q_q       <= q_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Q           = q_q;
  assign NOT_Q       = ~q_q;
  assign ILLEGAL     = illegal_q;
  assign ILLEGAL_CNT = cnt_q;

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("sr_flipflop_bank: CHANNELS must be 1..32");
  end
  if (SYNC_STAGES == 1 || SYNC_STAGES > 3 || SYNC_STAGES < 0) begin : g_bad_sync
    $error("sr_flipflop_bank: SYNC_STAGES must be 0, 2 or 3");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("sr_flipflop_bank: CNT_W must be at least 1");
  end

endmodule

// File: tb/tb_sr_flipflop_bank.sv
// Self-checking bench for sr_flipflop_bank: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the bank.
module tb_sr_flipflop_bank;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          CLK = 1'b0;
  logic          N_RESET;
  logic [CH-1:0] s, r, s1, r1;
  logic [1:0]    mode;
  logic          cnt_clr;

  logic [CH-1:0] q, nq, ill;
  logic [CW-1:0] cnt;
  logic [CH-1:0] q1, nq1, ill1;
  logic [CW-1:0] cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CH-1:0] exp_q;
  logic [CH-1:0] exp_ill;
  int            exp_cnt;
  logic [CH-1:0] s_pipe[$];
  logic [CH-1:0] r_pipe[$];

  sr_flipflop_bank #(.CHANNELS(CH), .SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
    .CLK         (CLK),
    .N_RESET     (N_RESET),
    .S           (s),
    .R           (r),
    .MODE        (mode),
    .CNT_CLR     (cnt_clr),
    .Q           (q),
    .NOT_Q       (nq),
    .ILLEGAL     (ill),
    .ILLEGAL_CNT (cnt)
  );

  sr_flipflop_bank #(.CHANNELS(CH), .SYNC_STAGES(0), .CNT_W(CW)) dut_nosync (
    .CLK         (CLK),
    .N_RESET     (N_RESET),
    .S           (s1),
    .R           (r1),
    .MODE        (mode),
    .CNT_CLR     (cnt_clr),
    .Q           (q1),
    .NOT_Q       (nq1),
    .ILLEGAL     (ill1),
    .ILLEGAL_CNT (cnt1)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    exp_q   = '0;
    exp_ill = '0;
    exp_cnt = 0;
    s_pipe.delete();
    r_pipe.delete();
    for (int i = 0; i < SYNC; i++) begin
      s_pipe.push_back('0);
      r_pipe.push_back('0);
    end
  endtask

  // Advance one rising edge, updating the behavioural model from the inputs
  // that were present at that edge, then step 1 ns past the edge for sampling.
  task automatic tick();
    logic [CH-1:0] ss, rs;
    @(posedge CLK);
    s_pipe.push_back(s);
    r_pipe.push_back(r);
    ss = s_pipe.pop_front();
    rs = r_pipe.pop_front();
    exp_ill = '0;
    for (int i = 0; i < CH; i++) begin
      if (ss[i] && rs[i]) begin
        if (mode == 2'b01)      exp_q[i] = 1'b1;
        else if (mode == 2'b10) exp_q[i] = 1'b0;
        else if (mode == 2'b11) exp_q[i] = ~exp_q[i];
        if (mode != 2'b11)      exp_ill[i] = 1'b1;
      end else if (ss[i]) begin
        exp_q[i] = 1'b1;
      end else if (rs[i]) begin
        exp_q[i] = 1'b0;
      end
    end
    if (cnt_clr)              exp_cnt = 0;
    else if (exp_ill != '0)   exp_cnt = (exp_cnt < CMAX) ? exp_cnt + 1 : CMAX;
    #1;
  endtask

  task automatic test_reset();
    N_RESET = 1'b0;
    s = '0; r = '0; s1 = '0; r1 = '0; mode = 2'b00; cnt_clr = 1'b0;
    model_reset();
    #12;
    n_checks++; if (q !== 4'b0000) begin n_fail++; $display("FAIL reset_q: got %b expected 0000", q); end
    n_checks++; if (nq !== 4'b1111) begin n_fail++; $display("FAIL reset_not_q: got %b expected 1111", nq); end
    n_checks++; if (ill !== 4'b0000) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0000", ill); end
    n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    @(negedge CLK);
    N_RESET = 1'b1;
    // Build Q=1010 with one illegal cycle on channel 0 (reset-dominant).
    mode = 2'b10; s = 4'b1011; r = 4'b0001;
    tick();
    s = '0; r = '0;
    repeat (3) tick();
    n_checks++; if (q !== 4'b1010) begin n_fail++; $display("FAIL pre_reset_q: got %b expected 1010", q); end
    n_checks++; if (cnt !== CW'(exp_cnt) || exp_cnt != 1) begin n_fail++; $display("FAIL pre_reset_cnt: got %0d expected 1", cnt); end
    #2;
    N_RESET = 1'b0;
    #1;
    n_checks++; if (q !== 4'b0000) begin n_fail++; $display("FAIL midrun_reset_q: got %b expected 0000", q); end
    n_checks++; if (nq !== 4'b1111) begin n_fail++; $display("FAIL midrun_reset_not_q: got %b expected 1111", nq); end
    n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL midrun_reset_cnt: got %0d expected 0", cnt); end
    #3;
    N_RESET = 1'b1;
    model_reset();
  endtask

  task automatic test_set_reset();
    mode = 2'b00;
    s = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) s = '0;
      n_checks++; if (q[0] !== (k >= 3)) begin n_fail++; $display("FAIL set_latency k=%0d: got %b expected %b", k, q[0], (k >= 3)); end
      n_checks++; if (q !== exp_q) begin n_fail++; $display("FAIL set_q k=%0d: got %b expected %b", k, q, exp_q); end
      n_checks++; if (nq !== ~exp_q) begin n_fail++; $display("FAIL set_not_q k=%0d: got %b expected %b", k, nq, ~exp_q); end
    end
    r = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) r = '0;
      n_checks++; if (q[0] !== (k < 3)) begin n_fail++; $display("FAIL reset_latency k=%0d: got %b expected %b", k, q[0], (k < 3)); end
      n_checks++; if (nq !== ~exp_q) begin n_fail++; $display("FAIL reset_not_q k=%0d: got %b expected %b", k, nq, ~exp_q); end
    end
  endtask

  task automatic test_dominance(input logic [1:0] m, input logic exp_q1);
    int hits;
    hits = 0;
    mode = m;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    s = 4'b0010; r = 4'b0010;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 3) begin s = '0; r = '0; end
      if (ill[1] === 1'b1) hits++;
      n_checks++; if (ill !== exp_ill) begin n_fail++; $display("FAIL dom_illegal m=%0d k=%0d: got %b expected %b", m, k, ill, exp_ill); end
      n_checks++; if (q !== exp_q) begin n_fail++; $display("FAIL dom_q m=%0d k=%0d: got %b expected %b", m, k, q, exp_q); end
    end
    n_checks++; if (hits != 3) begin n_fail++; $display("FAIL dom_pulse_count m=%0d: got %0d expected 3", m, hits); end
    n_checks++; if (q[1] !== exp_q1) begin n_fail++; $display("FAIL dom_final m=%0d: got %b expected %b", m, q[1], exp_q1); end
    n_checks++; if (cnt !== 4'd3) begin n_fail++; $display("FAIL dom_cnt m=%0d: got %0d expected 3", m, cnt); end
  endtask

  task automatic test_toggle();
    logic [5:0] seq;
    int         cnt_before;
    seq = 6'b010100;
    cnt_before = exp_cnt;
    mode = 2'b11;
    n_checks++; if (q[2] !== 1'b0) begin n_fail++; $display("FAIL toggle_start: got %b expected 0", q[2]); end
    s = 4'b0100; r = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 4) begin s = '0; r = '0; end
      n_checks++; if (q[2] !== seq[k-1]) begin n_fail++; $display("FAIL toggle_seq k=%0d: got %b expected %b", k, q[2], seq[k-1]); end
      n_checks++; if (ill !== 4'b0000) begin n_fail++; $display("FAIL toggle_illegal k=%0d: got %b expected 0000", k, ill); end
    end
    n_checks++; if (cnt !== CW'(cnt_before)) begin n_fail++; $display("FAIL toggle_cnt: got %0d expected %0d", cnt, cnt_before); end
  endtask

  task automatic test_saturation();
    mode = 2'b01;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    s = 4'b1111; r = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_checks++; if (ill !== exp_ill) begin n_fail++; $display("FAIL sat_illegal k=%0d: got %b expected %b", k, ill, exp_ill); end
      n_checks++; if (cnt !== CW'(exp_cnt)) begin n_fail++; $display("FAIL sat_cnt k=%0d: got %0d expected %0d", k, cnt, exp_cnt); end
    end
    n_checks++; if (ill !== 4'b1111) begin n_fail++; $display("FAIL sat_all_illegal: got %b expected 1111", ill); end
    n_checks++; if (cnt !== 4'd15) begin n_fail++; $display("FAIL sat_ceiling: got %0d expected 15", cnt); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL clr_priority: got %0d expected 0", cnt); end
    tick();
    s = '0; r = '0;
    n_checks++; if (cnt !== 4'd1) begin n_fail++; $display("FAIL clr_then_count: got %0d expected 1", cnt); end
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if (k % 20 == 0) mode = 2'($urandom_range(0, 3));
      s = 4'($urandom_range(0, 15));
      r = 4'($urandom_range(0, 15));
      cnt_clr = ($urandom_range(0, 15) == 0);
      tick();
      n_checks++; if (q !== exp_q) begin n_fail++; $display("FAIL rand_q k=%0d: got %b expected %b", k, q, exp_q); end
      n_checks++; if (nq !== ~exp_q) begin n_fail++; $display("FAIL rand_not_q k=%0d: got %b expected %b", k, nq, ~exp_q); end
      n_checks++; if (ill !== exp_ill) begin n_fail++; $display("FAIL rand_illegal k=%0d: got %b expected %b", k, ill, exp_ill); end
      n_checks++; if (cnt !== CW'(exp_cnt)) begin n_fail++; $display("FAIL rand_cnt k=%0d: got %0d expected %0d", k, cnt, exp_cnt); end
    end
    s = '0; r = '0; cnt_clr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_nosync();
    mode = 2'b00;
    n_checks++; if (q1 !== 4'b0000) begin n_fail++; $display("FAIL nosync_idle: got %b expected 0000", q1); end
    s1 = 4'b1010;
    tick();
    n_checks++; if (q1 !== 4'b1010) begin n_fail++; $display("FAIL nosync_one_edge: got %b expected 1010", q1); end
    s1 = 4'b0001; r1 = 4'b0010;
    tick();
    s1 = '0; r1 = '0;
    n_checks++; if (q1 !== 4'b1001) begin n_fail++; $display("FAIL nosync_mixed: got %b expected 1001", q1); end
    n_checks++; if (nq1 !== 4'b0110) begin n_fail++; $display("FAIL nosync_not_q: got %b expected 0110", nq1); end
    n_checks++; if (ill1 !== 4'b0000 || cnt1 !== 4'd0) begin n_fail++; $display("FAIL nosync_illegal: got %b/%0d expected 0000/0", ill1, cnt1); end
  endtask

  initial begin
    test_reset();
    test_set_reset();
    test_dominance(2'b01, 1'b1);
    test_dominance(2'b10, 1'b0);
    test_dominance(2'b00, 1'b0);
    test_dominance(2'b01, 1'b1);
    test_dominance(2'b00, 1'b1);
    test_toggle();
    test_saturation();
    test_random();
    test_nosync();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
